// File: rtl/vga_stream_timing.sv
// VGA timing generator: consumes an RGB332 pixel stream and drives RGB + hSync/vSync pins.
// Latency: io_pixel_ready is combinational on the pixel tick; RGB/sync outputs lag the counters by one tick.
// Backpressure: ready is asserted only in active pixel slots; a slot with no valid pixel is drawn black and flagged.
module vga_stream_timing #(
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 33,
  parameter int   PIXEL_DIV = 4,
  parameter logic SYNC_POL  = 1'b0
) (
  input  logic       io_clock,
  input  logic       io_reset_n,
  input  logic       io_enable,
  input  logic       io_pixel_valid,
  output logic       io_pixel_ready,
  input  logic [7:0] io_pixel_data,
  output logic [2:0] io_vga0_pixels_r,
  output logic [2:0] io_vga0_pixels_g,
  output logic [1:0] io_vga0_pixels_b,
  output logic       io_vga0_hSync,
  output logic       io_vga0_vSync,
  output logic       io_frameStart,
  output logic       io_underflow,
  input  logic       io_underflowClear
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // One extra bit of headroom so the sync window end never aliases to zero.
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int DW = (PIXEL_DIV > 1) ? $clog2(PIXEL_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(PIXEL_DIV - 1);
  localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [7:0]    rgb_q, rgb_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          uf_q, uf_d;

  logic tick;
  logic active;
  logic h_in_sync;
  logic v_in_sync;

  // Pixel tick, visible-region and sync-window decode from the current counters.
  always_comb begin
    tick      = io_enable & io_reset_n & (div_q == DIV_LAST);
    active    = (h_q < H_ACT_C) & (v_q < V_ACT_C);
    h_in_sync = (h_q >= HS_BEG) & (h_q < HS_END);
    v_in_sync = (v_q >= VS_BEG) & (v_q < VS_END);
  end

  // Next state: divider/counters advance on the tick, outputs register one tick behind.
  always_comb begin
    div_d = div_q;
    h_d   = h_q;
    v_d   = v_q;
    rgb_d = rgb_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    if (!io_enable) begin
      // Idle: park everything so a rising enable restarts the frame at (0,0).
      div_d = '0;
      h_d   = '0;
      v_d   = '0;
      rgb_d = '0;
      hs_d  = ~SYNC_POL;
      vs_d  = ~SYNC_POL;
    end else if (tick) begin
      div_d = '0;
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
      rgb_d = (active & io_pixel_valid) ? io_pixel_data : 8'h00;
      hs_d  = h_in_sync ? SYNC_POL : ~SYNC_POL;
      vs_d  = v_in_sync ? SYNC_POL : ~SYNC_POL;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  // Sticky underflow: a starved active slot sets it, and setting beats a simultaneous clear.
  always_comb begin
    uf_d = uf_q;
    if (tick & active & ~io_pixel_valid) begin
      uf_d = 1'b1;
    end else if (io_underflowClear) begin
      uf_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge io_clock) begin
    if (!io_reset_n) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
      rgb_q <= '0;
      hs_q  <= ~SYNC_POL;
      vs_q  <= ~SYNC_POL;
      uf_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      rgb_q <= rgb_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      uf_q  <= uf_d;
    end
  end

  assign io_pixel_ready   = tick & active;
  assign io_frameStart    = tick & (h_q == '0) & (v_q == '0);
  assign io_vga0_pixels_r = rgb_q[7:5];
  assign io_vga0_pixels_g = rgb_q[4:2];
  assign io_vga0_pixels_b = rgb_q[1:0];
  assign io_vga0_hSync    = hs_q;
  assign io_vga0_vSync    = vs_q;
  assign io_underflow     = uf_q;

endmodule

// File: tb/tb_vga_stream_timing.sv
// Bench for vga_stream_timing with a small raster so several whole frames fit in the run.
// Reference model derives position from a running cycle count: pixel = cycles / DIV.
// Directed phases: reset, clean frames, random stream, mid-line reset, enable drop, underflow set/clear.
module tb_vga_stream_timing;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int DIV = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT * DIV;

  logic       clk = 1'b0;
  logic       rst_n, en, valid, clr;
  logic [7:0] data;
  logic       rdy, fs, hs, vs, uf;
  logic [2:0] r, g;
  logic [1:0] b;

  always #5 clk = ~clk;

  vga_stream_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .PIXEL_DIV(DIV), .SYNC_POL(1'b0)
  ) dut (
    .io_clock(clk), .io_reset_n(rst_n), .io_enable(en),
    .io_pixel_valid(valid), .io_pixel_ready(rdy), .io_pixel_data(data),
    .io_vga0_pixels_r(r), .io_vga0_pixels_g(g), .io_vga0_pixels_b(b),
    .io_vga0_hSync(hs), .io_vga0_vSync(vs), .io_frameStart(fs),
    .io_underflow(uf), .io_underflowClear(clr)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_cnt = 0;
  int fs_n = 0, fs_t0 = 0, fs_t1 = 0;

  // Reference model state: cycles run since the last fresh start, plus expected output registers.
  int         run_cnt = 0;
  logic [7:0] m_rgb = 8'h00;
  logic       m_hs = 1'b1, m_vs = 1'b1, m_uf = 1'b0;

  function automatic logic m_tick();
    return rst_n && en && ((run_cnt % DIV) == DIV - 1);
  endfunction
  function automatic int m_h();
    return (run_cnt / DIV) % HT;
  endfunction
  function automatic int m_v();
    return (run_cnt / DIV / HT) % VT;
  endfunction
  function automatic logic m_act();
    return (m_h() < HA) && (m_v() < VA);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: compare at the falling edge, then advance the model across the rising edge.
  task automatic step();
    logic e_rdy, e_fs, t;
    int h, v;
    @(negedge clk);
    t     = m_tick();
    e_rdy = t && m_act();
    e_fs  = t && (m_h() == 0) && (m_v() == 0);
    chk("ready", rdy, e_rdy);
    chk("frameStart", fs, e_fs);
    chk("r", r, m_rgb[7:5]);
    chk("g", g, m_rgb[4:2]);
    chk("b", b, m_rgb[1:0]);
    chk("hSync", hs, m_hs);
    chk("vSync", vs, m_vs);
    chk("underflow", uf, m_uf);
    if (rdy) rdy_cnt++;
    if (fs) begin
      if (fs_n == 0) fs_t0 = cyc;
      if (fs_n == 1) fs_t1 = cyc;
      fs_n++;
    end
    @(posedge clk);
    if (!rst_n) begin
      run_cnt = 0; m_rgb = 8'h00; m_hs = 1'b1; m_vs = 1'b1; m_uf = 1'b0;
    end else if (!en) begin
      run_cnt = 0; m_rgb = 8'h00; m_hs = 1'b1; m_vs = 1'b1;
      if (clr) m_uf = 1'b0;
    end else begin
      if (t) begin
        h = m_h();
        v = m_v();
        m_rgb = (m_act() && valid) ? data : 8'h00;
        m_hs  = !((h >= HA + HF) && (h < HA + HF + HS));
        m_vs  = !((v >= VA + VF) && (v < VA + VF + VS));
        if (m_act() && !valid) m_uf = 1'b1;
        else if (clr) m_uf = 1'b0;
      end else if (clr) begin
        m_uf = 1'b0;
      end
      run_cnt++;
    end
    cyc++;
    #1;
  endtask

  initial begin
    logic found;
    rst_n = 1'b0; en = 1'b1; valid = 1'b1; clr = 1'b0; data = 8'h00;
    @(posedge clk);
    #1;

    // Reset state.
    for (int i = 0; i < 3; i++) begin
      data = 8'($urandom);
      step();
    end

    // Two clean frames, valid always high: ready count and frameStart period.
    rst_n = 1'b1;
    rdy_cnt = 0;
    fs_n = 0;
    for (int i = 0; i < FR; i++) begin
      data = 8'($urandom);
      step();
    end
    chk("ready_per_frame", rdy_cnt, HA * VA);
    for (int i = 0; i < FR; i++) begin
      data = 8'($urandom);
      step();
    end
    chk("frame_period", fs_t1 - fs_t0, FR);

    // Random stream with starved slots and occasional clears.
    for (int i = 0; i < 3 * FR; i++) begin
      data  = 8'($urandom);
      valid = ($urandom_range(0, 7) != 0);
      clr   = ($urandom_range(0, 15) == 0);
      step();
    end
    valid = 1'b1;
    clr   = 1'b0;

    // Reset mid-line, then restart.
    found = 1'b0;
    for (int i = 0; i < 2 * FR && !found; i++) begin
      if (m_h() == 5 && m_v() == 1) found = 1'b1;
      else begin
        data = 8'($urandom);
        step();
      end
    end
    chk("find_midline", found, 1'b1);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      data = 8'($urandom);
      step();
    end

    // Enable dropped mid-frame, then a fresh frame.
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      data  = 8'($urandom);
      valid = $urandom_range(0, 1) != 0;
      step();
    end
    en = 1'b1;
    valid = 1'b1;
    for (int i = 0; i < FR; i++) begin
      data = 8'($urandom);
      step();
    end

    // Single starved slot, stickiness, clear, and set-beats-clear.
    for (int pass = 0; pass < 2; pass++) begin
      found = 1'b0;
      for (int i = 0; i < FR && !found; i++) begin
        if (m_tick() && m_act()) found = 1'b1;
        else begin
          data = 8'($urandom);
          step();
        end
      end
      chk("find_slot", found, 1'b1);
      valid = 1'b0;
      clr   = (pass == 1);
      data  = 8'hE3;
      step();
      valid = 1'b1;
      clr   = 1'b0;
      for (int i = 0; i < 6; i++) begin
        data = 8'($urandom);
        step();
      end
      chk("underflow_sticky", uf, 1'b1);
      clr = 1'b1;
      step();
      clr = 1'b0;
      step();
      chk("underflow_cleared", uf, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
